// File: rtl/flux_capture_pkg.sv
// Shared definitions for the flux capture FIFO: word layout, tags and
// the saturating counter helper used by the loss accounting.
package flux_capture_pkg;

   localparam int WORD_W = 18;
   localparam int PAY_W  = 16;

   localparam logic [1:0] TAG_EDGE  = 2'b00;
   localparam logic [1:0] TAG_INDEX = 2'b01;
   localparam logic [1:0] TAG_DROP  = 2'b10;
   localparam logic [1:0] TAG_RSVD  = 2'b11;  // never emitted

   typedef struct packed {
      logic [1:0]       tag;
      logic [PAY_W-1:0] payload;
   } flux_word_t;

   // 16-bit add of a small increment, clamped at 0xFFFF
   function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] b);
      logic [16:0] s;
      s = {1'b0, a} + {15'b0, b};
      return s[16] ? 16'hFFFF : s[15:0];
   endfunction

endpackage

// File: rtl/flux_fifo_ram.sv
// Simple dual-port storage: one write port, one registered read port.
// Read-first on address collision; no reset so it maps onto block RAM.
module flux_fifo_ram #(
   parameter  int DEPTH  = 512,
   parameter  int WIDTH  = 18,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [WIDTH-1:0]  wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [WIDTH-1:0]  rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Write port and registered read port share the clock
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/flux_capture_fifo.sv
// Flux-interval capture FIFO: tags edges, index marks and loss markers,
// buffers them and presents them on a first-word-fall-through stream.
// The RAM read register doubles as the output register; out_valid tracks it.
module flux_capture_fifo
   import flux_capture_pkg::*;
#(
   parameter  int DEPTH  = 512,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              enable,
   input  logic              clear,
   input  logic              edge_detected,
   input  logic [15:0]       edge_interval,
   input  logic              index_pulse,
   output logic [WORD_W-1:0] m_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [ADDR_W:0]   level,
   output logic              overflow,
   output logic [15:0]       drop_total
);

   localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] PTR_ONE  = (ADDR_W+1)'(1);

   logic [ADDR_W:0]   wr_ptr, rd_ptr;
   logic              out_valid;
   logic              idx_pend, drop_pend;
   logic [15:0]       burst_cnt;
   logic [WORD_W-1:0] ram_q;

   logic       accept, full, ram_rd;
   logic       ev_edge, ev_idx;
   logic       wr_en, wr_drop, wr_idx;
   logic       edge_lost, idx_lost;
   logic [1:0] loss_n;
   flux_word_t wr_word;

   assign level   = (wr_ptr - rd_ptr) + (ADDR_W+1)'(out_valid);
   assign accept  = out_valid & m_ready;
   // a read being accepted this cycle frees a slot before the write lands
   assign full    = (level == FULL_LVL) & ~accept;
   assign ram_rd  = (wr_ptr != rd_ptr) & (~out_valid | accept) & ~clear;
   assign ev_edge = enable & edge_detected;
   assign ev_idx  = enable & index_pulse;
   assign loss_n  = {1'b0, edge_lost} + {1'b0, idx_lost};

   assign m_valid = out_valid;
   assign m_data  = out_valid ? ram_q : '0;

   // Write-slot arbiter: DROP marker > EDGE > INDEX, plus loss detection
   always_comb begin
      wr_en     = 1'b0;
      wr_drop   = 1'b0;
      wr_idx    = 1'b0;
      edge_lost = 1'b0;
      idx_lost  = 1'b0;
      wr_word   = '0;
      if (!clear) begin
         if (drop_pend && !full) begin
            wr_en     = 1'b1;
            wr_drop   = 1'b1;
            wr_word   = '{tag: TAG_DROP, payload: burst_cnt};
            edge_lost = ev_edge;
         end else if (ev_edge) begin
            if (full) begin
               edge_lost = 1'b1;
            end else begin
               wr_en   = 1'b1;
               wr_word = '{tag: TAG_EDGE, payload: edge_interval};
            end
         end else if ((idx_pend || ev_idx) && !full) begin
            wr_en   = 1'b1;
            wr_idx  = 1'b1;
            wr_word = '{tag: TAG_INDEX, payload: 16'h0000};
         end
         // a second index while one is still waiting cannot be queued
         idx_lost = ev_idx & idx_pend & ~wr_idx;
      end
   end

   // Pointers, output-register valid, pending flags and loss counters
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         out_valid  <= 1'b0;
         idx_pend   <= 1'b0;
         drop_pend  <= 1'b0;
         burst_cnt  <= '0;
         overflow   <= 1'b0;
         drop_total <= '0;
      end else if (clear) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         out_valid  <= 1'b0;
         idx_pend   <= 1'b0;
         drop_pend  <= 1'b0;
         burst_cnt  <= '0;
         overflow   <= 1'b0;
         drop_total <= '0;
      end else begin
         if (wr_en)  wr_ptr <= wr_ptr + PTR_ONE;
         if (ram_rd) rd_ptr <= rd_ptr + PTR_ONE;
         if (ram_rd)      out_valid <= 1'b1;
         else if (accept) out_valid <= 1'b0;
         idx_pend  <= idx_pend ? (ev_idx | ~wr_idx) : (ev_idx & ~wr_idx);
         burst_cnt <= sat_add16(wr_drop ? 16'h0000 : burst_cnt, loss_n);
         drop_pend <= (drop_pend & ~wr_drop) | (loss_n != 2'd0);
         if (loss_n != 2'd0) begin
            overflow   <= 1'b1;
            drop_total <= sat_add16(drop_total, loss_n);
         end
      end
   end

   flux_fifo_ram #(
      .DEPTH (DEPTH),
      .WIDTH (WORD_W)
   ) u_ram (
      .clk   (clk),
      .we    (wr_en),
      .waddr (wr_ptr[ADDR_W-1:0]),
      .wdata (wr_word),
      .re    (ram_rd),
      .raddr (rd_ptr[ADDR_W-1:0]),
      .rdata (ram_q)
   );

endmodule

// File: tb/tb_flux_capture_fifo.sv
// Bench for flux_capture_fifo: queue-based reference model checked every
// cycle, directed scenarios with literal expectations, random traffic.
module tb_flux_capture_fifo;
   import flux_capture_pkg::*;

   localparam int DEPTH = 4;
   localparam int AW    = $clog2(DEPTH);

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          enable = 1'b0;
   logic          clear = 1'b0;
   logic          edge_detected = 1'b0;
   logic [15:0]   edge_interval = 16'h0;
   logic          index_pulse = 1'b0;
   logic          m_ready = 1'b0;
   logic [17:0]   m_data;
   logic          m_valid;
   logic [AW:0]   level;
   logic          overflow;
   logic [15:0]   drop_total;

   flux_capture_fifo #(.DEPTH(DEPTH)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .enable        (enable),
      .clear         (clear),
      .edge_detected (edge_detected),
      .edge_interval (edge_interval),
      .index_pulse   (index_pulse),
      .m_data        (m_data),
      .m_valid       (m_valid),
      .m_ready       (m_ready),
      .level         (level),
      .overflow      (overflow),
      .drop_total    (drop_total)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;
   int t = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, t);
   endtask

   // reference model: every held word with the cycle it was written
   logic [17:0] mq[$];
   int          mc[$];
   logic        m_ipend = 1'b0, m_dpend = 1'b0, m_ovf = 1'b0;
   int          m_burst = 0, m_dtot = 0;
   // words the DUT handed over
   logic [17:0] log_d[$];
   int          log_c[$];

   logic        exp_v, acc, full, ev_e, ev_i, hw;
   logic [17:0] w;
   int          lost;

   // compare DUT against the model mid-cycle, then advance the model
   always @(negedge clk) begin
      if (!reset_n) begin
         mq.delete(); mc.delete();
         m_ipend = 0; m_dpend = 0; m_ovf = 0; m_burst = 0; m_dtot = 0;
         check("rst_m_valid", m_valid, 0);
         check("rst_m_data", m_data, 0);
         check("rst_level", level, 0);
         check("rst_overflow", overflow, 0);
         check("rst_drop_total", drop_total, 0);
      end else begin
         // a word is presented two cycles after it was written, in order
         exp_v = (mq.size() > 0) && (t >= mc[0] + 2);
         check("m_valid", m_valid, exp_v);
         if (exp_v) check("m_data", m_data, mq[0]);
         check("level", level, mq.size());
         check("overflow", overflow, m_ovf);
         check("drop_total", drop_total, m_dtot);
         if (m_valid && m_ready) begin
            log_d.push_back(m_data);
            log_c.push_back(t);
         end
         if (clear) begin
            mq.delete(); mc.delete();
            m_ipend = 0; m_dpend = 0; m_ovf = 0; m_burst = 0; m_dtot = 0;
         end else begin
            acc  = exp_v && m_ready;
            full = (mq.size() == DEPTH) && !acc;
            ev_e = enable && edge_detected;
            ev_i = enable && index_pulse;
            lost = 0; hw = 0; w = '0;
            if (m_dpend && !full) begin
               w = {TAG_DROP, 16'(m_burst)}; m_burst = 0; m_dpend = 0; hw = 1;
               if (ev_e) lost++;
            end else if (ev_e) begin
               if (full) lost++;
               else begin w = {TAG_EDGE, edge_interval}; hw = 1; end
            end
            if (!hw && !full && (m_ipend || ev_i)) begin
               w = {TAG_INDEX, 16'h0000}; hw = 1;
               m_ipend = m_ipend && ev_i;
            end else if (ev_i) begin
               if (m_ipend) lost++;
               m_ipend = 1;
            end
            if (lost > 0) begin
               m_burst = (m_burst + lost > 65535) ? 65535 : m_burst + lost;
               m_dtot  = (m_dtot + lost > 65535) ? 65535 : m_dtot + lost;
               m_ovf   = 1; m_dpend = 1;
            end
            if (acc) begin void'(mq.pop_front()); void'(mc.pop_front()); end
            if (hw) begin mq.push_back(w); mc.push_back(t); end
         end
      end
      t++;
   end

   task automatic step(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic edge_pulse(input logic [15:0] v, input logic idx);
      edge_detected = 1; edge_interval = v; index_pulse = idx;
      step(1);
      edge_detected = 0; index_pulse = 0;
   endtask

   task automatic log_clear();
      log_d.delete(); log_c.delete();
   endtask

   logic [15:0] exp_e[$];

   initial begin
      int n0, nbad;
      step(3);
      reset_n = 1; enable = 1; m_ready = 1;
      step(2);

      // single edge: two-cycle latency, level returns to zero
      log_clear(); n0 = t;
      edge_pulse(16'h0123, 0);
      step(5);
      check("t1_count", log_d.size(), 1);
      if (log_d.size() >= 1) begin
         check("t1_data", log_d[0], 18'h00123);
         check("t1_latency", log_c[0] - n0, 2);
      end
      check("t1_level", level, 0);

      // edge and index together: edge first, index next
      log_clear();
      edge_pulse(16'h0040, 1);
      step(6);
      check("t2_count", log_d.size(), 2);
      if (log_d.size() >= 2) begin
         check("t2_edge", log_d[0], 18'h00040);
         check("t2_index", log_d[1], 18'h10000);
      end
      check("t2_drops", drop_total, 0);

      // overflow: seven edges into four slots with the consumer stalled
      m_ready = 0;
      for (int k = 1; k <= 7; k++) edge_pulse(16'(k), 0);
      step(2);
      check("t3_level", level, 4);
      check("t3_overflow", overflow, 1);
      check("t3_drop_total", drop_total, 3);
      log_clear(); m_ready = 1;
      step(8);
      check("t3_count", log_d.size(), 5);
      if (log_d.size() >= 5) begin
         for (int k = 0; k < 4; k++) check("t3_edge", log_d[k], 18'(k + 1));
         check("t3_drop_marker", log_d[4], 18'h20003);
      end
      edge_pulse(16'h0008, 0);
      step(4);
      check("t3_after_count", log_d.size(), 6);
      if (log_d.size() >= 6) check("t3_after_edge", log_d[5], 18'h00008);
      check("t3_sticky", overflow, 1);

      // clear with a full FIFO and a loss marker pending
      clear = 1; step(1); clear = 0;
      m_ready = 0;
      for (int k = 1; k <= 5; k++) edge_pulse(16'(16 + k), 0);
      step(1);
      check("t6_level_before", level, 4);
      check("t6_drops_before", drop_total, 1);
      log_clear();
      clear = 1; step(1); clear = 0;
      check("t6_level", level, 0);
      check("t6_overflow", overflow, 0);
      check("t6_drop_total", drop_total, 0);
      check("t6_m_valid", m_valid, 0);
      m_ready = 1;
      step(8);
      check("t6_no_marker", log_d.size(), 0);

      // asynchronous reset in the middle of a burst
      m_ready = 0;
      for (int k = 0; k < 3; k++) edge_pulse(16'h0A00 + 16'(k), 0);
      step(1);
      check("t5_level_before", level, 3);
      reset_n = 0;
      #1;
      check("t5_async_valid", m_valid, 0);
      check("t5_async_level", level, 0);
      step(2);
      reset_n = 1; m_ready = 1;
      step(1);
      log_clear(); n0 = t;
      edge_pulse(16'h0BEE, 0);
      step(5);
      check("t5_count", log_d.size(), 1);
      if (log_d.size() >= 1) begin
         check("t5_data", log_d[0], 18'h00BEE);
         check("t5_latency", log_c[0] - n0, 2);
      end

      // 1000 edges with a randomly stalling consumer: order preserved
      log_clear(); exp_e.delete();
      for (int k = 0; k < 1000; k++) begin
         edge_detected = 1;
         edge_interval = 16'($urandom);
         exp_e.push_back(edge_interval);
         m_ready = ($urandom_range(0, 3) != 0);
         step(1);
         edge_detected = 0;
         repeat ($urandom_range(2, 4)) begin
            m_ready = ($urandom_range(0, 3) != 0);
            step(1);
         end
      end
      m_ready = 1;
      step(10);
      check("t4_count", log_d.size(), 1000);
      nbad = 0;
      for (int k = 0; k < 1000 && k < log_d.size(); k++)
         if (log_d[k] !== {TAG_EDGE, exp_e[k]}) nbad++;
      check("t4_order_errors", nbad, 0);
      check("t4_overflow", overflow, 0);

      // free-running random traffic including losses, index and clear
      for (int k = 0; k < 1500; k++) begin
         edge_detected = ($urandom_range(0, 1) == 1);
         edge_interval = 16'($urandom);
         index_pulse   = ($urandom_range(0, 7) == 0);
         enable        = ($urandom_range(0, 7) != 0);
         m_ready       = ($urandom_range(0, 1) == 1);
         clear         = ($urandom_range(0, 63) == 0);
         step(1);
      end
      edge_detected = 0; index_pulse = 0; clear = 0; enable = 1; m_ready = 1;
      step(12);
      check("final_drained", level, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
